// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache: FSM state encoding and
// width-derivation helpers used by the interface, the top and the PLRU tree.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } cache_state_t;

    // Index width for a table of n entries; never narrower than one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Tag width left over once offset and set-index bits are removed
    function automatic int tag_w(input int addr_w, input int line_bytes, input int sets);
        return addr_w - $clog2(line_bytes) - $clog2(sets);
    endfunction

endpackage

// File: rtl/cache_assoc_if.sv
// CPU request port and physical-memory line port of the cache, bundled.
// The cache connects through the slave modport; the environment uses master.
interface cache_assoc_if #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_BYTES = 32
);
    logic [ADDR_W-1:0]       mem_address;
    logic [DATA_W-1:0]       mem_rdata;
    logic [DATA_W-1:0]       mem_wdata;
    logic                    mem_read;
    logic                    mem_write;
    logic [DATA_W/8-1:0]     mem_byte_enable;
    logic                    mem_resp;
    logic [ADDR_W-1:0]       pmem_address;
    logic [LINE_BYTES*8-1:0] pmem_rdata;
    logic [LINE_BYTES*8-1:0] pmem_wdata;
    logic                    pmem_read;
    logic                    pmem_write;
    logic                    pmem_resp;

    modport slave (
        input  mem_address, mem_wdata, mem_read, mem_write, mem_byte_enable,
               pmem_rdata, pmem_resp,
        output mem_rdata, mem_resp, pmem_address, pmem_wdata, pmem_read, pmem_write
    );

    modport master (
        output mem_address, mem_wdata, mem_read, mem_write, mem_byte_enable,
               pmem_rdata, pmem_resp,
        input  mem_rdata, mem_resp, pmem_address, pmem_wdata, pmem_read, pmem_write
    );
endinterface

// File: rtl/cache_plru.sv
// Tree pseudo-LRU for one set. Node n has children 2n+1 (left) and 2n+2
// (right); a node bit of 1 steers the victim search to the right subtree.
module cache_plru
    import cache_pkg::*;
#(
    parameter int WAYS = 2
) (
    input  logic [WAYS-2:0]          tree_i,
    input  logic [idx_w(WAYS)-1:0]   way_i,
    output logic [WAYS-2:0]          tree_o,
    output logic [idx_w(WAYS)-1:0]   victim_o
);
    localparam int LVL = $clog2(WAYS);

    // Walk the tree for the victim, and re-point the accessed path away
    always_comb begin
        logic [LVL-1:0] node;
        logic           dir;
        tree_o   = tree_i;
        victim_o = '0;
        node     = '0;
        for (int l = 0; l < LVL; l++) begin
            dir                 = tree_i[node];
            victim_o[LVL-1-l]   = dir;
            node                = LVL'((32'(node) << 1) + 32'd1 + 32'(dir));
        end
        node = '0;
        for (int l = 0; l < LVL; l++) begin
            dir          = way_i[LVL-1-l];
            tree_o[node] = ~dir;
            node         = LVL'((32'(node) << 1) + 32'd1 + 32'(dir));
        end
    end
endmodule

// File: rtl/cache_assoc.sv
// N-way set-associative write-back cache with tree PLRU replacement and
// byte-enabled writes. Optional performance counters: CACHE_PERF_CNT_EN.
module cache_assoc
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_BYTES = 32,
    parameter int SETS       = 8,
    parameter int WAYS       = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    cache_assoc_if.slave bus,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count,
    output logic [31:0]  wb_count
);
    localparam int LINE_W   = LINE_BYTES * 8;
    localparam int WORDS    = LINE_W / DATA_W;
    localparam int OFF_W    = $clog2(LINE_BYTES);
    localparam int BOFF_W   = $clog2(DATA_W / 8);
    localparam int SET_BITS = $clog2(SETS);
    localparam int TAG_W    = tag_w(ADDR_W, LINE_BYTES, SETS);
    localparam int SET_IW   = idx_w(SETS);
    localparam int WSEL_W   = idx_w(WORDS);
    localparam int WAY_W    = idx_w(WAYS);

    cache_state_t      state_q, state_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic              filled_q, filled_d;   // line just filled; next LOOKUP is the post-fill hit

    logic [LINE_W-1:0] data_q  [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [WAYS-2:0]   plru_q  [SETS];

    logic [SET_IW-1:0] set_s;
    logic [TAG_W-1:0]  tag_s;
    logic [WSEL_W-1:0] wsel_s;
    logic              hit_s, has_inv_s;
    logic [WAY_W-1:0]  hit_way_s, inv_way_s, plru_victim_s, miss_victim_s;
    logic [WAYS-2:0]   plru_upd_s;
    logic [LINE_W-1:0] hit_line_s, mask_line_s, merged_line_s;
    logic [DATA_W-1:0] wmask_s;
    logic              plru_we_s, word_we_s, clean_we_s, fill_we_s;
    logic              hit_inc_s, miss_inc_s, wb_inc_s;

    assign set_s  = SET_IW'((bus.mem_address >> OFF_W) & ADDR_W'(SETS - 1));
    assign tag_s  = TAG_W'(bus.mem_address >> (OFF_W + SET_BITS));
    assign wsel_s = WSEL_W'((bus.mem_address >> BOFF_W) & ADDR_W'(WORDS - 1));

    // Tag match across the indexed set and lowest-index invalid way
    always_comb begin
        hit_s     = 1'b0;
        hit_way_s = '0;
        has_inv_s = 1'b0;
        inv_way_s = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[set_s][WAY_W'(w)] && (tag_q[set_s][WAY_W'(w)] == tag_s)) begin
                hit_s     = 1'b1;
                hit_way_s = WAY_W'(w);
            end else begin
                hit_s     = hit_s;
            end
            if (!valid_q[set_s][WAY_W'(w)]) begin
                has_inv_s = 1'b1;
                inv_way_s = WAY_W'(w);
            end else begin
                has_inv_s = has_inv_s;
            end
        end
    end

    cache_plru #(.WAYS(WAYS)) u_plru (
        .tree_i   (plru_q[set_s]),
        .way_i    (hit_way_s),
        .tree_o   (plru_upd_s),
        .victim_o (plru_victim_s)
    );

    assign miss_victim_s = has_inv_s ? inv_way_s : plru_victim_s;
    assign hit_line_s    = data_q[set_s][hit_way_s];

    // Byte-lane write mask for the addressed word, placed within the line
    always_comb begin
        wmask_s = '0;
        for (int b = 0; b < DATA_W / 8; b++) begin
            wmask_s[b*8 +: 8] = {8{bus.mem_byte_enable[b]}};
        end
    end

    assign mask_line_s   = LINE_W'(wmask_s) << (DATA_W * wsel_s);
    assign merged_line_s = (hit_line_s & ~mask_line_s)
                         | ((LINE_W'(bus.mem_wdata) << (DATA_W * wsel_s)) & mask_line_s);
    assign bus.pmem_wdata = data_q[set_s][victim_q];

    // Next-state and output decode of the controller
    always_comb begin
        state_d          = state_q;
        victim_d         = victim_q;
        filled_d         = filled_q;
        bus.mem_resp     = 1'b0;
        bus.mem_rdata    = '0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        plru_we_s        = 1'b0;
        word_we_s        = 1'b0;
        clean_we_s       = 1'b0;
        fill_we_s        = 1'b0;
        hit_inc_s        = 1'b0;
        miss_inc_s       = 1'b0;
        wb_inc_s         = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.mem_read || bus.mem_write) state_d = LOOKUP;
                else                               state_d = IDLE;
            end
            LOOKUP: begin
                if (hit_s) begin
                    bus.mem_resp  = 1'b1;
                    bus.mem_rdata = DATA_W'(hit_line_s >> (DATA_W * wsel_s));
                    plru_we_s     = 1'b1;
                    word_we_s     = bus.mem_write && (bus.mem_byte_enable != '0);
                    hit_inc_s     = !filled_q;
                    filled_d      = 1'b0;
                    state_d       = IDLE;
                end else begin
                    victim_d   = miss_victim_s;
                    miss_inc_s = 1'b1;
                    if (valid_q[set_s][miss_victim_s] && dirty_q[set_s][miss_victim_s]) begin
                        wb_inc_s = 1'b1;
                        state_d  = WRITEBACK;
                    end else begin
                        state_d  = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = (ADDR_W'(tag_q[set_s][victim_q]) << (OFF_W + SET_BITS))
                                 | (ADDR_W'(set_s) << OFF_W);
                if (bus.pmem_resp) begin
                    clean_we_s = 1'b1;
                    state_d    = ALLOCATE;
                end else begin
                    state_d    = WRITEBACK;
                end
            end
            ALLOCATE: begin
                bus.pmem_address = bus.mem_address & ~ADDR_W'(LINE_BYTES - 1);
                if (filled_q) begin
                    state_d = LOOKUP;
                end else begin
                    bus.pmem_read = 1'b1;
                    if (bus.pmem_resp) begin
                        fill_we_s = 1'b1;
                        filled_d  = 1'b1;
                    end else begin
                        filled_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            victim_q <= '0;
            filled_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            filled_q <= filled_d;
        end
    end

    // Valid, dirty and PLRU bookkeeping, all cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            if (plru_we_s)  plru_q[set_s] <= plru_upd_s;
            if (word_we_s)  dirty_q[set_s][hit_way_s] <= 1'b1;
            if (clean_we_s) dirty_q[set_s][victim_q] <= 1'b0;
            if (fill_we_s) begin
                valid_q[set_s][victim_q] <= 1'b1;
                dirty_q[set_s][victim_q] <= 1'b0;
            end
        end
    end

    // Line data and tags: replaced on fill, merged on enabled write hits
    always_ff @(posedge clk) begin
        if (fill_we_s) begin
            data_q[set_s][victim_q] <= bus.pmem_rdata;
            tag_q[set_s][victim_q]  <= tag_s;
        end else if (word_we_s) begin
            data_q[set_s][hit_way_s] <= merged_line_s;
        end
    end

`ifdef CACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

    // Free-running wrapping event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
            wb_cnt_q   <= 32'd0;
        end else begin
            hit_cnt_q  <= hit_cnt_q  + {31'd0, hit_inc_s};
            miss_cnt_q <= miss_cnt_q + {31'd0, miss_inc_s};
            wb_cnt_q   <= wb_cnt_q   + {31'd0, wb_inc_s};
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
    assign wb_count   = wb_cnt_q;
`else
    logic perf_unused_s;
    assign perf_unused_s = ^{hit_inc_s, miss_inc_s, wb_inc_s};
    assign hit_count     = 32'd0;
    assign miss_count    = 32'd0;
    assign wb_count      = 32'd0;
`endif
endmodule

// File: tb/tb_cache_assoc.sv
// Bench for cache_assoc with default parameters: scoreboarded CPU reads,
// a three-cycle physical-memory model, eviction and mid-fill reset scenarios.
module tb_cache_assoc;
    localparam int LINE_W = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] hit_count, miss_count, wb_count;

    cache_assoc_if #(.ADDR_W(32), .DATA_W(32), .LINE_BYTES(32)) bus ();

    cache_assoc #(.ADDR_W(32), .DATA_W(32), .LINE_BYTES(32), .SETS(8), .WAYS(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .wb_count   (wb_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        logic [31:0] data;
    } exp_t;

    int                tests_run = 0;
    int                tests_failed = 0;
    exp_t              exp_q[$];
    logic [LINE_W-1:0] mem [int unsigned];
    int unsigned       rd_addr_q[$];
    int unsigned       wb_addr_q[$];
    logic [LINE_W-1:0] wb_data_q[$];
    int                exp_hits = 0, exp_misses = 0, exp_wbs = 0;
    int                pm_cnt = 0;
    exp_t              mon_e;

    function automatic logic [LINE_W-1:0] pattern_line(input logic [31:0] a);
        logic [LINE_W-1:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = {a[15:0], 16'(i)};
        return l;
    endfunction

    function automatic int perf(input int v);
`ifdef CACHE_PERF_CNT_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    // Physical memory: answers each request in its third cycle
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            pm_cnt = 0;
            bus.pmem_resp = 1'b0;
        end else if (bus.pmem_read || bus.pmem_write) begin
            pm_cnt++;
            if (pm_cnt == 3) begin
                pm_cnt = 0;
                bus.pmem_resp = 1'b1;
                if (bus.pmem_write) begin
                    mem[bus.pmem_address] = bus.pmem_wdata;
                    wb_addr_q.push_back(bus.pmem_address);
                    wb_data_q.push_back(bus.pmem_wdata);
                end else begin
                    if (!mem.exists(bus.pmem_address)) mem[bus.pmem_address] = pattern_line(bus.pmem_address);
                    bus.pmem_rdata = mem[bus.pmem_address];
                    rd_addr_q.push_back(bus.pmem_address);
                end
            end else begin
                bus.pmem_resp = 1'b0;
            end
        end else begin
            pm_cnt = 0;
            bus.pmem_resp = 1'b0;
        end
    end

    // Scoreboard: each mem_resp consumes one queued expectation
    always @(negedge clk) begin
        if (rst_n && bus.mem_resp) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_resp: mem_resp with no request outstanding, rdata=%h", bus.mem_rdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.chk) begin
                    tests_run++;
                    if (bus.mem_rdata !== mon_e.data) begin
                        tests_failed++;
                        $display("FAIL rdata: got %h, expected %h", bus.mem_rdata, mon_e.data);
                    end
                end
            end
        end
        if (bus.pmem_read === 1'b1 && bus.pmem_write === 1'b1) begin
            tests_failed++;
            $display("FAIL pmem_excl: pmem_read and pmem_write both 1, expected at most one");
        end
    end

    // kind: 0 hit (latency 1), 1 clean miss (6), 2 dirty miss (9)
    task automatic cpu_req(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic [31:0] exp_data, input int kind,
                           input string name);
        int   lat;
        int   want;
        exp_t e;
        want  = (kind == 0) ? 1 : ((kind == 1) ? 6 : 9);
        e.chk = !wr;
        e.data = exp_data;
        exp_q.push_back(e);
        if (kind == 0) exp_hits++;
        else           exp_misses++;
        if (kind == 2) exp_wbs++;
        @(posedge clk); #1;
        bus.mem_address = addr;
        bus.mem_read = !wr;
        bus.mem_write = wr;
        bus.mem_wdata = wdata;
        bus.mem_byte_enable = be;
        lat = 0;
        while (1) begin
            @(negedge clk);
            if (bus.mem_resp) break;
            lat++;
            if (lat > 50) break;
        end
        tests_run++;
        if (lat != want) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, lat, want);
        end
        @(posedge clk); #1;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.mem_resp, bus.pmem_read, bus.pmem_write} !== 3'b000 || bus.pmem_address !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: resp/rd/wr=%b addr=%h, expected 000 and 0",
                     {bus.mem_resp, bus.pmem_read, bus.pmem_write}, bus.pmem_address);
        end
        tests_run++;
        if ({hit_count, miss_count, wb_count} !== 96'd0) begin
            tests_failed++;
            $display("FAIL reset_counters: got %0d/%0d/%0d, expected 0/0/0", hit_count, miss_count, wb_count);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_clean_miss();
        cpu_req(32'h40, 1'b0, 32'd0, 4'h0, 32'hDEADBEEF, 1, "clean_miss");
        tests_run++;
        if (rd_addr_q.size() != 1 || rd_addr_q[0] != 32'h40 || wb_addr_q.size() != 0) begin
            tests_failed++;
            $display("FAIL clean_miss_pmem: reads=%0d writes=%0d, expected 1 read at 00000040 and 0 writes",
                     rd_addr_q.size(), wb_addr_q.size());
        end
    endtask

    task automatic test_hit();
        int n;
        n = rd_addr_q.size();
        cpu_req(32'h40, 1'b0, 32'd0, 4'h0, 32'hDEADBEEF, 0, "read_hit");
        tests_run++;
        if (rd_addr_q.size() != n || wb_addr_q.size() != 0) begin
            tests_failed++;
            $display("FAIL hit_no_pmem: reads=%0d writes=%0d, expected %0d and 0", rd_addr_q.size(), wb_addr_q.size(), n);
        end
    endtask

    task automatic test_byte_write();
        cpu_req(32'h40, 1'b1, 32'h12345678, 4'b0011, 32'd0, 0, "write_be0011");
        cpu_req(32'h40, 1'b0, 32'd0, 4'h0, 32'hDEAD5678, 0, "read_merged");
        cpu_req(32'h40, 1'b1, 32'hFFFFFFFF, 4'b0000, 32'd0, 0, "write_be0000");
        cpu_req(32'h40, 1'b0, 32'd0, 4'h0, 32'hDEAD5678, 0, "read_unchanged");
        cpu_req(32'h5C, 1'b0, 32'd0, 4'h0, 32'hA0000007, 0, "read_last_word");
    endtask

    task automatic test_evict();
        logic [LINE_W-1:0] l;
        cpu_req(32'h140, 1'b0, 32'd0, 4'h0, 32'h01400000, 1, "miss_0x140");
        cpu_req(32'h240, 1'b0, 32'd0, 4'h0, 32'h02400000, 2, "dirty_miss_0x240");
        tests_run++;
        if (wb_addr_q.size() != 1) begin
            tests_failed++;
            $display("FAIL wb_count_seen: got %0d writebacks, expected 1", wb_addr_q.size());
        end else begin
            l = wb_data_q[0];
            tests_run++;
            if (wb_addr_q[0] != 32'h40 || l[31:0] !== 32'hDEAD5678 || l[255:224] !== 32'hA0000007) begin
                tests_failed++;
                $display("FAIL wb_line: addr=%h w0=%h w7=%h, expected 00000040 DEAD5678 A0000007",
                         wb_addr_q[0], l[31:0], l[255:224]);
            end
        end
        tests_run++;
        if (rd_addr_q[rd_addr_q.size()-1] != 32'h240) begin
            tests_failed++;
            $display("FAIL fill_addr: got %h, expected 00000240", rd_addr_q[rd_addr_q.size()-1]);
        end
        cpu_req(32'h140, 1'b0, 32'd0, 4'h0, 32'h01400000, 0, "hit_0x140");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        e.chk = 1'b1; e.data = 32'h02400000; exp_q.push_back(e);
        e.chk = 1'b1; e.data = 32'h01400001; exp_q.push_back(e);
        exp_hits += 2;
        @(posedge clk); #1;
        bus.mem_address = 32'h240;
        bus.mem_read = 1'b1;
        lat = 0;
        while (!bus.mem_resp && lat < 50) begin @(negedge clk); lat++; end
        @(posedge clk); #1;
        bus.mem_address = 32'h144;
        lat = 0;
        while (1) begin
            @(negedge clk);
            if (bus.mem_resp) break;
            lat++;
            if (lat > 50) break;
        end
        tests_run++;
        if (lat != 1) begin
            tests_failed++;
            $display("FAIL back_to_back latency: got %0d cycles, expected 1", lat);
        end
        @(posedge clk); #1;
        bus.mem_read = 1'b0;
    endtask

    task automatic test_reset_midfill();
        int n;
        @(posedge clk); #1;
        bus.mem_address = 32'h40;
        bus.mem_read = 1'b1;
        exp_misses++;
        n = 0;
        while (!bus.pmem_read && n < 20) begin @(negedge clk); n++; end
        tests_run++;
        if (bus.pmem_read !== 1'b1) begin
            tests_failed++;
            $display("FAIL midfill_pending: pmem_read=%b, expected 1", bus.pmem_read);
        end
        tests_run++;
        if (hit_count !== perf(exp_hits) || miss_count !== perf(exp_misses) || wb_count !== perf(exp_wbs)) begin
            tests_failed++;
            $display("FAIL counters: got %0d/%0d/%0d, expected %0d/%0d/%0d", hit_count, miss_count, wb_count,
                     perf(exp_hits), perf(exp_misses), perf(exp_wbs));
        end
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.pmem_read !== 1'b0 || bus.mem_resp !== 1'b0 || bus.pmem_address !== 32'd0 || miss_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL async_reset: pmem_read=%b resp=%b addr=%h miss=%0d, expected 0 0 0 0",
                     bus.pmem_read, bus.mem_resp, bus.pmem_address, miss_count);
        end
        bus.mem_read = 1'b0;
        exp_hits = 0; exp_misses = 0; exp_wbs = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cpu_req(32'h40, 1'b0, 32'd0, 4'h0, 32'hDEAD5678, 1, "miss_after_reset");
        tests_run++;
        if (hit_count !== perf(exp_hits) || miss_count !== perf(exp_misses) || wb_count !== perf(exp_wbs)) begin
            tests_failed++;
            $display("FAIL counters_after_reset: got %0d/%0d/%0d, expected %0d/%0d/%0d", hit_count, miss_count,
                     wb_count, perf(exp_hits), perf(exp_misses), perf(exp_wbs));
        end
    endtask

    initial begin
        logic [LINE_W-1:0] l;
        bus.mem_address = 32'd0;
        bus.mem_wdata = 32'd0;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_byte_enable = 4'h0;
        bus.pmem_rdata = '0;
        bus.pmem_resp = 1'b0;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'hA0000000 + 32'(i);
        l[31:0] = 32'hDEADBEEF;
        mem[32'h40] = l;
        test_reset();
        test_clean_miss();
        test_hit();
        test_byte_write();
        test_evict();
        test_back_to_back();
        test_reset_midfill();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
